// File: rtl/vga_timing_pkg.sv
// Shared timing constants and pixel types for the VGA timing generator.
// Defaults describe 800x600 at 72 Hz from a 50 MHz pixel clock.
package vga_timing_pkg;

    localparam int CNT_W = 11;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int H_ACTIVE_DEF = 800;
    localparam int H_FP_DEF = 56;
    localparam int H_SYNC_DEF = 120;
    localparam int H_BP_DEF = 64;

    localparam int V_ACTIVE_DEF = 600;
    localparam int V_FP_DEF = 37;
    localparam int V_SYNC_DEF = 6;
    localparam int V_BP_DEF = 23;

    localparam int H_TOTAL_DEF =
        H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF =
        V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef logic [11:0] pixel_t;
    typedef logic [3:0] chan_t;

    function automatic chan_t pix_r(pixel_t p);
        return p[11:8];
    endfunction

    function automatic chan_t pix_g(pixel_t p);
        return p[7:4];
    endfunction

    function automatic chan_t pix_b(pixel_t p);
        return p[3:0];
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One timing axis: wrapping counter plus active and sync window decode.
// The wrap output is qualified by the enable so it can chain axes.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL = H_TOTAL_DEF,
    parameter int SYNC_START = H_ACTIVE_DEF + H_FP_DEF,
    parameter int SYNC_END = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF,
    parameter int ACTIVE = H_ACTIVE_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             wrap_o,
    output logic             in_active_o,
    output logic             in_sync_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_S = CNT_W'(SYNC_START);
    localparam logic [CNT_W-1:0] SYNC_E = CNT_W'(SYNC_END);
    localparam logic [CNT_W-1:0] ACT_E = CNT_W'(ACTIVE);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_last;

    assign at_last = (count_q == LAST);

    // Next count: hold, advance, or wrap to zero at the end of the axis
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = at_last ? '0 : count_q + 1'b1;
        end
    end

    // Counter register with synchronous reset back to the origin
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o = en_i && at_last;
    assign in_active_o = (count_q < ACT_E);
    assign in_sync_o = (count_q >= SYNC_S) && (count_q < SYNC_E);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing master: pixel address counters, blanking, registered RGB/sync.
// Outputs lag the presented address by exactly one pixel clock.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP = H_FP_DEF,
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP = V_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP = V_BP_DEF,
    parameter int SYNC_POL = 1
) (
    input  logic             vga_clk,
    input  logic             rst,
    input  logic [11:0]      vga_data,
    output logic [CNT_W-1:0] vga_haddr,
    output logic [CNT_W-1:0] vga_vaddr,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             active,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic SP = (SYNC_POL != 0);

    if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_timing
        $fatal(1, "vga_timing_gen: totals exceed 11-bit counters");
    end

    logic h_wrap;
    logic h_act;
    logic h_sync;
    logic v_wrap;
    logic v_act;
    logic v_sync;

    vga_axis_counter #(
        .TOTAL(H_TOTAL),
        .SYNC_START(H_ACTIVE + H_FP),
        .SYNC_END(H_ACTIVE + H_FP + H_SYNC),
        .ACTIVE(H_ACTIVE)
    ) u_h (
        .clk_i(vga_clk),
        .rst_i(rst),
        .en_i(1'b1),
        .count_o(vga_haddr),
        .wrap_o(h_wrap),
        .in_active_o(h_act),
        .in_sync_o(h_sync)
    );

    vga_axis_counter #(
        .TOTAL(V_TOTAL),
        .SYNC_START(V_ACTIVE + V_FP),
        .SYNC_END(V_ACTIVE + V_FP + V_SYNC),
        .ACTIVE(V_ACTIVE)
    ) u_v (
        .clk_i(vga_clk),
        .rst_i(rst),
        .en_i(h_wrap),
        .count_o(vga_vaddr),
        .wrap_o(v_wrap),
        .in_active_o(v_act),
        .in_sync_o(v_sync)
    );

    pixel_t rgb_q;
    pixel_t rgb_d;
    logic   act_q;
    logic   act_d;
    logic   hs_q;
    logic   hs_d;
    logic   vs_q;
    logic   vs_d;
    logic   fs_q;
    logic   fs_d;

    // Blank the returned pixel and decode sync levels for the current address
    always_comb begin
        act_d = h_act && v_act;
        rgb_d = act_d ? vga_data : '0;
        hs_d = h_sync ? SP : ~SP;
        vs_d = v_sync ? SP : ~SP;
        fs_d = v_wrap;
    end

    // Output stage: one-cycle aligned colour, syncs and frame strobe
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            rgb_q <= '0;
            act_q <= 1'b0;
            hs_q <= ~SP;
            vs_q <= ~SP;
            fs_q <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            act_q <= act_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            fs_q <= fs_d;
        end
    end

    assign vga_r = pix_r(rgb_q);
    assign vga_g = pix_g(rgb_q);
    assign vga_b = pix_b(rgb_q);
    assign vga_hs = hs_q;
    assign vga_vs = vs_q;
    assign active = act_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced timing set.
// Expected outputs come from a cycle-index model: h = t % HT, v = t / HT.
module tb_vga_timing_gen;

    localparam int HA = 16;
    localparam int HFP = 4;
    localparam int HS = 6;
    localparam int HBP = 4;
    localparam int VA = 10;
    localparam int VFP = 3;
    localparam int VS = 2;
    localparam int VBP = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int N_CYC = 2700;
    localparam int MID_RST_T = 2 * FRAME + 5 * HT + 8;

    logic        vga_clk;
    logic        rst;
    logic [11:0] vga_data;
    logic [10:0] vga_haddr;
    logic [10:0] vga_vaddr;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        active;
    logic        frame_start;

    int n_assert = 0;
    int n_fail = 0;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1)
    ) dut (
        .vga_clk(vga_clk),
        .rst(rst),
        .vga_data(vga_data),
        .vga_haddr(vga_haddr),
        .vga_vaddr(vga_vaddr),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .vga_hs(vga_hs),
        .vga_vs(vga_vs),
        .active(active),
        .frame_start(frame_start)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input longint obs,
                       input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int t;
        int h0;
        int v0;
        bit prev_rst;
        bit did_mid;
        logic [11:0] prev_data;
        logic [11:0] e_rgb;
        bit e_act;
        bit e_hs;
        bit e_vs;
        bit e_fs;
        longint cyc;
        longint last_fs;
        int fs_seen;
        int fs_exp;

        rst = 1'b1;
        vga_data = 12'hFFD;
        prev_rst = 1'b1;
        prev_data = vga_data;
        did_mid = 1'b0;
        t = 0;
        cyc = 0;
        last_fs = -1;
        fs_seen = 0;
        fs_exp = 0;

        for (int c = 0; c < N_CYC; c++) begin
            @(negedge vga_clk);
            cyc++;
            if (prev_rst) begin
                t = 0;
                e_rgb = '0;
                e_act = 1'b0;
                e_hs = 1'b0;
                e_vs = 1'b0;
                e_fs = 1'b0;
            end else begin
                h0 = t % HT;
                v0 = (t / HT) % VT;
                e_act = (h0 < HA) && (v0 < VA);
                e_rgb = e_act ? prev_data : 12'h000;
                e_hs = (h0 >= HA + HFP) && (h0 < HA + HFP + HS);
                e_vs = (v0 >= VA + VFP) && (v0 < VA + VFP + VS);
                e_fs = (h0 == HT - 1) && (v0 == VT - 1);
                t++;
            end
            if (e_fs) fs_exp++;

            chk("haddr", vga_haddr, t % HT);
            chk("vaddr", vga_vaddr, (t / HT) % VT);
            chk("red", vga_r, e_rgb[11:8]);
            chk("green", vga_g, e_rgb[7:4]);
            chk("blue", vga_b, e_rgb[3:0]);
            chk("active", active, e_act);
            chk("hsync", vga_hs, e_hs);
            chk("vsync", vga_vs, e_vs);
            chk("frame_start", frame_start, e_fs);

            if (frame_start === 1'b1) begin
                if (last_fs >= 0) chk("fs_period", cyc - last_fs, FRAME);
                last_fs = cyc;
                fs_seen++;
            end

            if (c < 2) begin
                rst = 1'b1;
            end else if (!prev_rst && !did_mid && t == MID_RST_T) begin
                rst = 1'b1;
                did_mid = 1'b1;
                last_fs = -1;
            end else begin
                rst = 1'b0;
            end

            if (fs_seen == 0 && !did_mid) vga_data = 12'hFFD;
            else vga_data = 12'($urandom);

            prev_rst = rst;
            prev_data = vga_data;
        end

        chk("fs_count", fs_seen, fs_exp);
        chk("mid_reset_hit", did_mid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
